// File: rtl/game_clock_pkg.sv
// rtl/game_clock_pkg.sv - shared FSM state and mode constants for the game clock
package game_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int MODE_SUDDEN  = 0;
  localparam int MODE_FISCHER = 1;
  localparam int MODE_DELAY   = 2;

endpackage

// File: rtl/game_clock_if.sv
// rtl/game_clock_if.sv - button/tick inputs and display-side outputs of the game clock
interface game_clock_if #(
  parameter int N_PLAYERS = 2,
  parameter int TIME_W    = 12
);
  localparam int ACT_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;

  logic                        tick;
  logic                        start_btn;
  logic                        new_game;
  logic [N_PLAYERS-1:0]        press;
  logic [N_PLAYERS*TIME_W-1:0] time_flat;
  logic [ACT_W-1:0]            active;
  logic [N_PLAYERS-1:0]        flag;
  logic                        running;
  logic                        game_over;

  modport master (
    output tick, start_btn, new_game, press,
    input  time_flat, active, flag, running, game_over
  );

  modport slave (
    input  tick, start_btn, new_game, press,
    output time_flat, active, flag, running, game_over
  );
endinterface

// File: rtl/player_timer.sv
// rtl/player_timer.sv - one player's remaining-seconds counter
// Decrement is applied before the increment so a same-cycle tick and turn end both count.
module player_timer #(
  parameter int TIME_W    = 12,
  parameter int INIT_TIME = 300,
  parameter int INC       = 5
) (
  input  logic              clk_one,
  input  logic              reset,
  input  logic              load,
  input  logic              dec,
  input  logic              add_inc,
  output logic [TIME_W-1:0] value,
  output logic              is_one
);
  localparam logic [TIME_W:0] MAX_V = {1'b0, {TIME_W{1'b1}}};

  logic [TIME_W-1:0] dec_val;
  logic [TIME_W:0]   sum;

  always_comb begin
    dec_val = (dec && value != '0) ? value - TIME_W'(1) : value;
    sum     = {1'b0, dec_val} + (TIME_W+1)'(INC);
  end

  always_ff @(posedge clk_one or posedge reset) begin
    if (reset)        value <= TIME_W'(INIT_TIME);
    else if (load)    value <= TIME_W'(INIT_TIME);
    else if (add_inc) value <= (sum > MAX_V) ? MAX_V[TIME_W-1:0] : sum[TIME_W-1:0];
    else              value <= dec_val;
  end

  assign is_one = (value == TIME_W'(1));
endmodule

// File: rtl/game_clock_core.sv
// rtl/game_clock_core.sv - N-player game clock: FSM, turn pointer, delay counter, flags
module game_clock_core
  import game_clock_pkg::*;
#(
  parameter int N_PLAYERS = 2,
  parameter int TIME_W    = 12,
  parameter int INIT_TIME = 300,
  parameter int MODE      = 0,
  parameter int INC       = 5,
  parameter int DELAY     = 5
) (
  input logic        clk_one,
  input logic        reset,
  game_clock_if.slave bus
);
  localparam int ACT_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;

  state_t               state, state_nx;
  logic [ACT_W-1:0]     active;
  logic [TIME_W-1:0]    delay_cnt;
  logic [N_PLAYERS-1:0] flag;
  logic [N_PLAYERS-1:0] is_one;
  logic [TIME_W-1:0]    value [N_PLAYERS];
  logic                 running, game_over;
  logic                 in_run, tick_ev, press_ev, delay_busy, dec_act, timeout, do_switch, load_all;

  // start_btn in RUN pre-empts any tick or press of the same cycle
  always_comb begin
    in_run     = (state == ST_RUN) && !bus.start_btn;
    tick_ev    = in_run && bus.tick;
    press_ev   = in_run && bus.press[active];
    delay_busy = (MODE == MODE_DELAY) && (delay_cnt != '0);
    dec_act    = tick_ev && !delay_busy;
    timeout    = dec_act && is_one[active];
    do_switch  = press_ev && !timeout;
    load_all   = bus.new_game && ((state == ST_PAUSE) || (state == ST_OVER));
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (bus.start_btn) state_nx = ST_RUN;
      ST_RUN: begin
        if (bus.start_btn)  state_nx = ST_PAUSE;
        else if (timeout)   state_nx = ST_OVER;
      end
      ST_PAUSE: begin
        if (bus.new_game)       state_nx = ST_IDLE;
        else if (bus.start_btn) state_nx = ST_RUN;
      end
      ST_OVER:  if (bus.new_game) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_one or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      running   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nx;
      running   <= (state_nx == ST_RUN);
      game_over <= (state_nx == ST_OVER);
    end
  end

  always_ff @(posedge clk_one or posedge reset) begin
    if (reset) begin
      active    <= '0;
      delay_cnt <= TIME_W'(DELAY);
      flag      <= '0;
    end else if (load_all) begin
      active    <= '0;
      delay_cnt <= TIME_W'(DELAY);
      flag      <= '0;
    end else begin
      if (timeout) flag[active] <= 1'b1;
      if (do_switch) begin
        active    <= (active == ACT_W'(N_PLAYERS-1)) ? '0 : active + ACT_W'(1);
        delay_cnt <= TIME_W'(DELAY);
      end else if (tick_ev && delay_busy) begin
        delay_cnt <= delay_cnt - TIME_W'(1);
      end
    end
  end

  for (genvar i = 0; i < N_PLAYERS; i++) begin : g_timer
    player_timer #(
      .TIME_W   (TIME_W),
      .INIT_TIME(INIT_TIME),
      .INC      (INC)
    ) u_timer (
      .clk_one(clk_one),
      .reset  (reset),
      .load   (load_all),
      .dec    (dec_act && (active == ACT_W'(i))),
      .add_inc(do_switch && (MODE == MODE_FISCHER) && (active == ACT_W'(i))),
      .value  (value[i]),
      .is_one (is_one[i])
    );
    assign bus.time_flat[i*TIME_W +: TIME_W] = value[i];
  end

  assign bus.active    = active;
  assign bus.flag      = flag;
  assign bus.running   = running;
  assign bus.game_over = game_over;
endmodule

// File: tb/tb_game_clock_core.sv
// tb/tb_game_clock_core.sv - directed checks of game_clock_core across modes and player counts
module tb_game_clock_core;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0, st = 1'b0, ng = 1'b0;
  logic [2:0] press = 3'b000;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  game_clock_if #(.N_PLAYERS(2), .TIME_W(12)) if_a ();
  game_clock_if #(.N_PLAYERS(2), .TIME_W(12)) if_b ();
  game_clock_if #(.N_PLAYERS(2), .TIME_W(12)) if_c ();
  game_clock_if #(.N_PLAYERS(2), .TIME_W(12)) if_d ();
  game_clock_if #(.N_PLAYERS(3), .TIME_W(12)) if_e ();

  assign if_a.tick = tick; assign if_a.start_btn = st; assign if_a.new_game = ng; assign if_a.press = press[1:0];
  assign if_b.tick = tick; assign if_b.start_btn = st; assign if_b.new_game = ng; assign if_b.press = press[1:0];
  assign if_c.tick = tick; assign if_c.start_btn = st; assign if_c.new_game = ng; assign if_c.press = press[1:0];
  assign if_d.tick = tick; assign if_d.start_btn = st; assign if_d.new_game = ng; assign if_d.press = press[1:0];
  assign if_e.tick = tick; assign if_e.start_btn = st; assign if_e.new_game = ng; assign if_e.press = press;

  game_clock_core #(.N_PLAYERS(2), .TIME_W(12), .INIT_TIME(300), .MODE(0), .INC(5), .DELAY(5))
    dut_a (.clk_one(clk), .reset(rst), .bus(if_a));
  game_clock_core #(.N_PLAYERS(2), .TIME_W(12), .INIT_TIME(300), .MODE(1), .INC(5), .DELAY(5))
    dut_b (.clk_one(clk), .reset(rst), .bus(if_b));
  game_clock_core #(.N_PLAYERS(2), .TIME_W(12), .INIT_TIME(300), .MODE(2), .INC(5), .DELAY(5))
    dut_c (.clk_one(clk), .reset(rst), .bus(if_c));
  game_clock_core #(.N_PLAYERS(2), .TIME_W(12), .INIT_TIME(2), .MODE(0), .INC(5), .DELAY(5))
    dut_d (.clk_one(clk), .reset(rst), .bus(if_d));
  game_clock_core #(.N_PLAYERS(3), .TIME_W(12), .INIT_TIME(2), .MODE(0), .INC(5), .DELAY(5))
    dut_e (.clk_one(clk), .reset(rst), .bus(if_e));

  typedef struct packed {
    logic        tick;
    logic        st;
    logic        ng;
    logic [2:0]  press;
    logic [11:0] t0;
    logic [11:0] t1;
    logic        act;
    logic        run;
    logic        over;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic step(input logic t, input logic s, input logic n, input logic [2:0] p);
    tick = t; st = s; ng = n; press = p;
    @(posedge clk);
    #1;
    tick = 1'b0; st = 1'b0; ng = 1'b0; press = 3'b000;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // tick, start, new_game, press, t0, t1, active, running, game_over
    vt[0]  = {1'b0, 1'b0, 1'b0, 3'b000, 12'd300, 12'd300, 1'b0, 1'b0, 1'b0};
    vt[1]  = {1'b1, 1'b0, 1'b0, 3'b000, 12'd300, 12'd300, 1'b0, 1'b0, 1'b0};
    vt[2]  = {1'b0, 1'b0, 1'b0, 3'b001, 12'd300, 12'd300, 1'b0, 1'b0, 1'b0};
    vt[3]  = {1'b0, 1'b1, 1'b0, 3'b000, 12'd300, 12'd300, 1'b0, 1'b1, 1'b0};
    vt[4]  = {1'b1, 1'b0, 1'b0, 3'b000, 12'd299, 12'd300, 1'b0, 1'b1, 1'b0};
    vt[5]  = {1'b1, 1'b0, 1'b0, 3'b000, 12'd298, 12'd300, 1'b0, 1'b1, 1'b0};
    vt[6]  = {1'b0, 1'b0, 1'b0, 3'b010, 12'd298, 12'd300, 1'b0, 1'b1, 1'b0};
    vt[7]  = {1'b0, 1'b0, 1'b0, 3'b001, 12'd298, 12'd300, 1'b1, 1'b1, 1'b0};
    vt[8]  = {1'b1, 1'b0, 1'b0, 3'b000, 12'd298, 12'd299, 1'b1, 1'b1, 1'b0};
    vt[9]  = {1'b1, 1'b0, 1'b0, 3'b010, 12'd298, 12'd298, 1'b0, 1'b1, 1'b0};
    vt[10] = {1'b1, 1'b1, 1'b0, 3'b000, 12'd298, 12'd298, 1'b0, 1'b0, 1'b0};
    vt[11] = {1'b1, 1'b0, 1'b0, 3'b001, 12'd298, 12'd298, 1'b0, 1'b0, 1'b0};
    vt[12] = {1'b0, 1'b1, 1'b0, 3'b000, 12'd298, 12'd298, 1'b0, 1'b1, 1'b0};
    vt[13] = {1'b1, 1'b0, 1'b0, 3'b000, 12'd297, 12'd298, 1'b0, 1'b1, 1'b0};
    vt[14] = {1'b0, 1'b1, 1'b0, 3'b000, 12'd297, 12'd298, 1'b0, 1'b0, 1'b0};
    vt[15] = {1'b0, 1'b1, 1'b1, 3'b000, 12'd300, 12'd300, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    #12;
    chk("reset t0", 32'(if_a.time_flat[11:0]), 300);
    chk("reset t1", 32'(if_a.time_flat[23:12]), 300);
    chk("reset act", 32'(if_a.active), 0);
    chk("reset flag", 32'(if_a.flag), 0);
    chk("reset run", 32'(if_a.running), 0);
    chk("reset over", 32'(if_a.game_over), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(vt[i].tick, vt[i].st, vt[i].ng, vt[i].press);
      chk($sformatf("vec%0d t0", i), 32'(if_a.time_flat[11:0]), 32'(vt[i].t0));
      chk($sformatf("vec%0d t1", i), 32'(if_a.time_flat[23:12]), 32'(vt[i].t1));
      chk($sformatf("vec%0d act", i), 32'(if_a.active), 32'(vt[i].act));
      chk($sformatf("vec%0d run", i), 32'(if_a.running), 32'(vt[i].run));
      chk($sformatf("vec%0d over", i), 32'(if_a.game_over), 32'(vt[i].over));
    end

    // sudden death: 10 ticks
    do_reset();
    step(1'b0, 1'b1, 1'b0, 3'b000);
    ticks(10);
    chk("sd t0", 32'(if_a.time_flat[11:0]), 290);
    chk("sd t1", 32'(if_a.time_flat[23:12]), 300);
    chk("sd act", 32'(if_a.active), 0);
    chk("sd run", 32'(if_a.running), 1);

    // Fischer increment
    do_reset();
    step(1'b0, 1'b1, 1'b0, 3'b000);
    ticks(3);
    step(1'b0, 1'b0, 1'b0, 3'b001);
    chk("fis t0", 32'(if_b.time_flat[11:0]), 302);
    chk("fis act", 32'(if_b.active), 1);
    step(1'b0, 1'b0, 1'b0, 3'b001);
    chk("fis t0 again", 32'(if_b.time_flat[11:0]), 302);
    chk("fis t1 again", 32'(if_b.time_flat[23:12]), 300);
    chk("fis act again", 32'(if_b.active), 1);

    // simple delay; the same run drives dut_c
    do_reset();
    step(1'b0, 1'b1, 1'b0, 3'b000);
    ticks(7);
    chk("dly t0", 32'(if_c.time_flat[11:0]), 298);
    step(1'b0, 1'b0, 1'b0, 3'b001);
    ticks(4);
    chk("dly t1 4", 32'(if_c.time_flat[23:12]), 300);
    ticks(1);
    chk("dly t1 5", 32'(if_c.time_flat[23:12]), 300);
    ticks(1);
    chk("dly t1 6", 32'(if_c.time_flat[23:12]), 299);
    chk("dly t0 held", 32'(if_c.time_flat[11:0]), 298);

    // time-out with INIT=2
    do_reset();
    step(1'b0, 1'b1, 1'b0, 3'b000);
    ticks(2);
    chk("to t0", 32'(if_d.time_flat[11:0]), 0);
    chk("to flag", 32'(if_d.flag), 1);
    chk("to over", 32'(if_d.game_over), 1);
    chk("to run", 32'(if_d.running), 0);
    ticks(3);
    step(1'b1, 1'b1, 1'b0, 3'b011);
    chk("to hold t0", 32'(if_d.time_flat[11:0]), 0);
    chk("to hold t1", 32'(if_d.time_flat[23:12]), 2);
    chk("to hold act", 32'(if_d.active), 0);
    chk("to hold over", 32'(if_d.game_over), 1);
    step(1'b0, 1'b0, 1'b1, 3'b000);
    chk("ng t0", 32'(if_d.time_flat[11:0]), 2);
    chk("ng t1", 32'(if_d.time_flat[23:12]), 2);
    chk("ng flag", 32'(if_d.flag), 0);
    chk("ng over", 32'(if_d.game_over), 0);
    chk("ng run", 32'(if_d.running), 0);

    // three players: rotation, then tick+press on the last second
    do_reset();
    step(1'b0, 1'b1, 1'b0, 3'b000);
    step(1'b0, 1'b0, 1'b0, 3'b001);
    chk("n3 act1", 32'(if_e.active), 1);
    step(1'b0, 1'b0, 1'b0, 3'b010);
    chk("n3 act2", 32'(if_e.active), 2);
    step(1'b0, 1'b0, 1'b0, 3'b100);
    chk("n3 act0", 32'(if_e.active), 0);
    ticks(1);
    chk("n3 t0 1", 32'(if_e.time_flat[11:0]), 1);
    step(1'b1, 1'b0, 1'b0, 3'b001);
    chk("n3 t0 0", 32'(if_e.time_flat[11:0]), 0);
    chk("n3 flag", 32'(if_e.flag), 1);
    chk("n3 act kept", 32'(if_e.active), 0);
    chk("n3 over", 32'(if_e.game_over), 1);

    // pause holds, then asynchronous reset mid-run
    do_reset();
    step(1'b0, 1'b1, 1'b0, 3'b000);
    ticks(4);
    step(1'b0, 1'b1, 1'b0, 3'b000);
    ticks(5);
    chk("pause t0", 32'(if_a.time_flat[11:0]), 296);
    chk("pause run", 32'(if_a.running), 0);
    step(1'b0, 1'b1, 1'b0, 3'b000);
    step(1'b0, 1'b0, 1'b0, 3'b001);
    #2;
    rst = 1'b1;
    #1;
    chk("arst t0", 32'(if_a.time_flat[11:0]), 300);
    chk("arst t1", 32'(if_a.time_flat[23:12]), 300);
    chk("arst act", 32'(if_a.active), 0);
    chk("arst run", 32'(if_a.running), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
